// File: rtl/dm_cache_pkg.sv
// Shared types, constants and address-field helpers for the direct-mapped cache.
package dm_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL,
    CMPLT
  } state_e;

  localparam int          WORDS_PER_LINE = 4;
  localparam logic [15:0] ADDR_NOP       = 16'h0000;
  localparam logic [15:0] DATA_NOP       = 16'h0000;

  // Field helpers return zero-extended 16-bit values; callers size-cast to the field width.
  function automatic logic [15:0] tag_of(input logic [15:0] a, input int idx_w);
    return a >> (idx_w + 3);
  endfunction

  function automatic logic [15:0] index_of(input logic [15:0] a, input int idx_w);
    return (a >> 3) & ((16'h0001 << idx_w) - 16'h0001);
  endfunction

  function automatic logic [1:0] word_of(input logic [15:0] a);
    return a[2:1];
  endfunction

  function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] w);
    return line[{w, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/dm_cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one line-fill/word-write port.
module dm_cache_array
  import dm_cache_pkg::*;
#(
  parameter int LINES = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic [63:0]      rd_line_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             word_we_i,
  input  logic [1:0]       word_sel_i,
  input  logic [15:0]      word_data_i,
  input  logic             line_we_i,
  input  logic [TAG_W-1:0] line_tag_i,
  input  logic [63:0]      line_data_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [63:0]      data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tags and data are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= line_tag_i;
      data_q[wr_idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][{word_sel_i, 4'b0000} +: 16] <= word_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache with miss-handling FSM.
// Define DM_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int LINES   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        cache_hit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 13 - IDX_W;

  if (LINES < 4 || LINES > 256 || (LINES & (LINES - 1)) != 0 || MEM_LAT < 1) begin : g_cfg_check
    $error("dm_cache_ctrl: unsupported LINES/MEM_LAT");
  end

  state_e           state_q, state_d;
  logic [15:0]      req_addr_q, req_addr_d;
  logic [15:0]      req_data_q, req_data_d;
  logic             req_wr_q, req_wr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       ret_q, ret_d;
  logic             issued_q, issued_d;
  logic [47:0]      fbuf_q, fbuf_d;

  logic [15:0]      cur_addr;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic [1:0]       cur_word;

  logic             arr_valid, arr_dirty;
  logic [TAG_W-1:0] arr_tag;
  logic [63:0]      arr_line;
  logic             word_we, line_we;
  logic [15:0]      word_data;
  logic             hit, req_any, req_bad;

  // While a miss is outstanding the array is addressed by the latched request.
  assign cur_addr = (state_q == IDLE) ? addr : req_addr_q;
  assign cur_idx  = IDX_W'(index_of(cur_addr, IDX_W));
  assign cur_tag  = TAG_W'(tag_of(cur_addr, IDX_W));
  assign cur_word = word_of(cur_addr);

  assign req_any = rd | wr;
  assign req_bad = req_any & ((rd & wr) | addr[0]);
  assign hit     = arr_valid && (arr_tag == cur_tag);

  dm_cache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_idx_i    (cur_idx),
    .rd_valid_o  (arr_valid),
    .rd_dirty_o  (arr_dirty),
    .rd_tag_o    (arr_tag),
    .rd_line_o   (arr_line),
    .wr_idx_i    (cur_idx),
    .word_we_i   (word_we),
    .word_sel_i  (cur_word),
    .word_data_i (word_data),
    .line_we_i   (line_we),
    .line_tag_i  (cur_tag),
    .line_data_i ({mem_rdata, fbuf_q})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      ret_q    <= 2'd0;
      issued_q <= 1'b0;
      req_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ret_q    <= ret_d;
      issued_q <= issued_d;
      req_wr_q <= req_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    req_data_q <= req_data_d;
    fbuf_q     <= fbuf_d;
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_wr_d   = req_wr_q;
    cnt_d      = cnt_q;
    ret_d      = ret_q;
    issued_d   = issued_q;
    fbuf_d     = fbuf_q;
    data_out   = DATA_NOP;
    done       = 1'b0;
    stall      = 1'b0;
    cache_hit  = 1'b0;
    err        = 1'b0;
    mem_addr   = ADDR_NOP;
    mem_wdata  = DATA_NOP;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    word_we    = 1'b0;
    word_data  = data_in;
    line_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_bad) begin
          err  = 1'b1;
          done = 1'b1;
        end else if (req_any && hit) begin
          done      = 1'b1;
          cache_hit = 1'b1;
          data_out  = line_word(arr_line, cur_word);
          word_we   = wr;
        end else if (req_any) begin
          req_addr_d = addr;
          req_data_d = data_in;
          req_wr_d   = wr;
          cnt_d      = 2'd0;
          ret_d      = 2'd0;
          issued_d   = 1'b0;
          state_d    = (arr_valid && arr_dirty) ? EVICT : FILL;
        end
      end

      EVICT: begin
        stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {arr_tag, cur_idx, cnt_q, 1'b0};
        mem_wdata = line_word(arr_line, cnt_q);
        if (!mem_stall) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = FILL;
        end
      end

      // Reads are issued back to back; returns are shifted into fbuf in order.
      FILL: begin
        stall = 1'b1;
        if (!issued_q) begin
          mem_rd   = 1'b1;
          mem_addr = {cur_tag, cur_idx, cnt_q, 1'b0};
          if (!mem_stall) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) issued_d = 1'b1;
          end
        end
        if (mem_rvalid) begin
          ret_d = ret_q + 2'd1;
          if (ret_q == 2'd3) begin
            line_we = 1'b1;
            state_d = CMPLT;
          end else begin
            fbuf_d = {mem_rdata, fbuf_q[47:16]};
          end
        end
      end

      CMPLT: begin
        done      = 1'b1;
        data_out  = req_wr_q ? req_data_q : line_word(arr_line, cur_word);
        word_we   = req_wr_q;
        word_data = req_data_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        miss_start;

  assign miss_start = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      if (done && cache_hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'h0001;
      if (miss_start && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'h0001;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: request-level cache/memory model plus a per-cycle monitor.
module tb_dm_cache_ctrl;

  localparam int LINES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr, data_in;
  logic        rd, wr;
  logic [15:0] data_out;
  logic        done, stall, cache_hit, err;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic        mem_stall;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef DM_CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  dm_cache_ctrl #(.LINES(LINES), .MEM_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .data_in    (data_in),
    .rd         (rd),
    .wr         (wr),
    .data_out   (data_out),
    .done       (done),
    .stall      (stall),
    .cache_hit  (cache_hit),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_stall  (mem_stall),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_wr;
    logic [15:0] a;
    logic [15:0] d;
  } tr_t;

  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          t0 = 0;
  logic [15:0] bmem    [32768];
  logic [15:0] ref_mem [32768];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int          m_tag   [LINES];
  tr_t         trq[$];

  logic        exp_active = 1'b0;
  logic        got_done = 1'b0;
  logic        e_err, e_hit, e_chk_data;
  logic [15:0] e_data;
  int          e_lat;
  int          last_lat;
  logic        last_hit, last_err;
  logic [15:0] last_data;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'hA5C3;
  endfunction

  function automatic tr_t tq(input int i);
    tr_t t;
    t = '0;
    if (i < trq.size()) t = trq[i];
    return t;
  endfunction

  initial begin : cyc_counter
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  // Main memory: records accepted traffic, returns reads two cycles after acceptance.
  initial begin : memory
    logic        acc, p0_v, p1_v;
    logic [15:0] acc_a, p0_a, p1_a;
    tr_t         t;
    p0_v = 1'b0; p1_v = 1'b0; p0_a = 16'h0; p1_a = 16'h0;
    mem_rvalid = 1'b0; mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      acc = 1'b0; acc_a = 16'h0;
      if (rst_n && mem_wr && !mem_stall) begin
        bmem[mem_addr[15:1]] = mem_wdata;
        t.is_wr = 1'b1; t.a = mem_addr; t.d = mem_wdata;
        trq.push_back(t);
      end
      if (rst_n && mem_rd && !mem_stall) begin
        acc = 1'b1; acc_a = mem_addr;
        t.is_wr = 1'b0; t.a = mem_addr; t.d = 16'h0;
        trq.push_back(t);
      end
      @(posedge clk);
      #1;
      p1_v = p0_v; p1_a = p0_a;
      p0_v = acc;  p0_a = acc_a;
      mem_rvalid = p1_v;
      mem_rdata  = p1_v ? bmem[p1_a[15:1]] : 16'h0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("stall_and_done", 48'(stall && done), 48'(0));
        chk("mem_rd_and_wr", 48'(mem_rd && mem_wr), 48'(0));
        if (!stall) chk("traffic_while_not_busy", 48'(mem_rd || mem_wr), 48'(0));
        if (exp_active && !got_done && done) begin
          got_done  = 1'b1;
          last_lat  = cycle - t0;
          last_hit  = cache_hit;
          last_err  = err;
          last_data = data_out;
          chk("err", 48'(err), 48'(e_err));
          chk("cache_hit", 48'(cache_hit), 48'(e_hit));
          chk("latency", 48'(cycle - t0), 48'(e_lat));
          if (e_chk_data) chk("data_out", 48'(data_out), 48'(e_data));
        end else if (!exp_active) begin
          chk("done_without_request", 48'(done), 48'(0));
        end
      end
    end
  end

  task automatic model_reset();
    for (int l = 0; l < LINES; l++) begin
      if (m_valid[l] && m_dirty[l]) begin
        for (int w = 0; w < 4; w++) ref_mem[(m_tag[l] << 7) | (l << 2) | w] = bmem[(m_tag[l] << 7) | (l << 2) | w];
      end
      m_valid[l] = 1'b0;
      m_dirty[l] = 1'b0;
    end
  endtask

  task automatic req(input logic [15:0] a, input logic [15:0] d, input logic r, input logic w,
                     input int s_at, input int s_len, input logic [15:0] held);
    int   idx, tg, k, n;
    logic is_err, is_hit, vdirty;
    tr_t  exp_q[$];
    tr_t  t;
    is_err = (r && w) || a[0];
    idx    = int'(a[7:3]);
    tg     = int'(a[15:8]);
    is_hit = !is_err && m_valid[idx] && (m_tag[idx] == tg);
    vdirty = m_valid[idx] && m_dirty[idx];
    if (!is_err && !is_hit) begin
      if (vdirty) begin
        for (int i = 0; i < 4; i++) begin
          t.is_wr = 1'b1;
          t.a = 16'((m_tag[idx] << 8) | (idx << 3) | (i << 1));
          t.d = ref_mem[t.a[15:1]];
          exp_q.push_back(t);
        end
      end
      for (int i = 0; i < 4; i++) begin
        t.is_wr = 1'b0;
        t.a = 16'((tg << 8) | (idx << 3) | (i << 1));
        t.d = 16'h0;
        exp_q.push_back(t);
      end
    end
    e_err      = is_err;
    e_hit      = is_hit;
    e_lat      = (is_err || is_hit) ? 0 : (7 + (vdirty ? 4 : 0) + s_len);
    e_chk_data = !is_err && (r || !is_hit);
    e_data     = r ? ref_mem[a[15:1]] : d;
    trq.delete();

    @(posedge clk);
    #1;
    addr = a; data_in = d; rd = r; wr = w;
    t0 = cycle;
    got_done = 1'b0;
    exp_active = 1'b1;
    n = 0;
    while (!got_done && n < 60) begin
      @(posedge clk);
      n++;
      if (!got_done) begin
        #1;
        k = cycle - t0;
        mem_stall = (k >= s_at) && (k < s_at + s_len);
        if (mem_stall) begin
          #1;
          chk("stall_hold_rd", 48'(mem_rd), 48'(1));
          chk("stall_hold_addr", 48'(mem_addr), 48'(held));
        end
      end
    end
    #1;
    rd = 1'b0; wr = 1'b0; mem_stall = 1'b0;
    exp_active = 1'b0;
    chk("done_seen", 48'(got_done), 48'(1));
    chk("traffic_count", 48'(trq.size()), 48'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) chk("traffic_item", 48'(tq(i)), 48'(exp_q[i]));

    if (!is_err) begin
      if (!is_hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_dirty[idx] = 1'b0;
      end
      if (w) begin
        m_dirty[idx] = 1'b1;
        ref_mem[a[15:1]] = d;
      end
    end
  endtask

  initial begin : driver
    for (int i = 0; i < 32768; i++) begin
      bmem[i] = init_val(i);
      ref_mem[i] = bmem[i];
    end
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0;
    end
    rst_n = 1'b0; addr = 16'h0; data_in = 16'h0; rd = 1'b0; wr = 1'b0; mem_stall = 1'b0;
    #3;
    chk("rst_done", 48'(done), 48'(0));
    chk("rst_stall", 48'(stall), 48'(0));
    chk("rst_err", 48'(err), 48'(0));
    chk("rst_hit", 48'(cache_hit), 48'(0));
    chk("rst_mem_rd", 48'(mem_rd), 48'(0));
    chk("rst_mem_wr", 48'(mem_wr), 48'(0));
    chk("rst_mem_addr", 48'(mem_addr), 48'(0));
    chk("rst_data_out", 48'(data_out), 48'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    req(16'h0040, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("pin_fill_addr", 48'(tq(i).a), 48'(16'h0040 + 16'(2 * i)));
      chk("pin_fill_is_read", 48'(tq(i).is_wr), 48'(0));
    end
    chk("pin_clean_miss_lat", 48'(last_lat), 48'(7));
    chk("pin_clean_miss_hit", 48'(last_hit), 48'(0));

    req(16'h0040, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_hit_lat", 48'(last_lat), 48'(0));
    chk("pin_hit_flag", 48'(last_hit), 48'(1));

    req(16'h0042, 16'hBEEF, 1'b0, 1'b1, 99, 0, 16'h0);
    chk("pin_write_hit", 48'(last_hit), 48'(1));
    req(16'h0042, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_read_beef", 48'(last_data), 48'(16'hBEEF));

    req(16'h1042, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("pin_evict_is_write", 48'(tq(i).is_wr), 48'(1));
      chk("pin_evict_addr", 48'(tq(i).a), 48'(16'h0040 + 16'(2 * i)));
    end
    chk("pin_evict_beef", 48'(tq(1).d), 48'(16'hBEEF));
    chk("pin_refill_first", 48'({tq(4).is_wr, tq(4).a}), 48'(17'h01040));
    chk("pin_dirty_miss_lat", 48'(last_lat), 48'(11));

    req(16'h0040, 16'h1111, 1'b1, 1'b1, 99, 0, 16'h0);
    chk("pin_err_rdwr", 48'(last_err), 48'(1));
    req(16'h0041, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_err_odd", 48'(last_err), 48'(1));
    req(16'h1042, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_hit_after_err", 48'(last_hit), 48'(1));

    req(16'h2050, 16'h1234, 1'b0, 1'b1, 99, 0, 16'h0);
    chk("pin_write_miss_data", 48'(last_data), 48'(16'h1234));
    req(16'h2050, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_read_1234", 48'(last_data), 48'(16'h1234));

    req(16'h0080, 16'h0000, 1'b1, 1'b0, 2, 3, 16'h0082);
    chk("pin_stalled_fill_lat", 48'(last_lat), 48'(10));

    @(posedge clk);
    #1 addr = 16'h00C0; rd = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0; rd = 1'b0;
    #1;
    chk("midrst_done", 48'(done), 48'(0));
    chk("midrst_stall", 48'(stall), 48'(0));
    chk("midrst_mem_rd", 48'(mem_rd), 48'(0));
    chk("midrst_mem_wr", 48'(mem_wr), 48'(0));
    chk("midrst_mem_addr", 48'(mem_addr), 48'(0));
    chk("midrst_hit", 48'(cache_hit), 48'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);

    req(16'h1042, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_miss_after_reset", 48'(last_hit), 48'(0));
    req(16'h2050, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_dirty_dropped_lat", 48'(last_lat), 48'(7));
    req(16'h0080, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    req(16'h0080, 16'h0000, 1'b1, 1'b0, 99, 0, 16'h0);
    chk("pin_rehit", 48'(last_hit), 48'(1));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
